// File: rtl/cordic_updated.sv
// ----------------------------------------------------------------------------
// cordic_updated
// Fully pipelined CORDIC rotation-mode engine, signed Q16.16 datapath.
// Rotates (x0,y0) by angle z0 (radians) and returns the rotated vector scaled
// by the CORDIC gain K (~1.64676); no gain compensation is applied.
// One sample accepted per clock, ITER clocks of latency, results in order.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset, clears every pipeline register
//   x0, y0    : input vector, signed Q16.16
//   z0        : rotation angle, signed Q16.16 radians (|z0| <= pi/2)
//   X, Y      : rotated vector (K-scaled), registered stage ITER-1 outputs
//   in_valid  : (CORDIC_VALID_EN only) sample qualifier
//   out_valid : (CORDIC_VALID_EN only) in_valid delayed by ITER clocks
//
// Optional feature macro: CORDIC_VALID_EN adds the in_valid/out_valid
// sideband. Data registers advance every clock regardless of valid.
// ----------------------------------------------------------------------------
module cordic_updated #(
    parameter int unsigned W    = 32,
    parameter int unsigned ITER = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] x0,
    input  logic signed [W-1:0] y0,
    input  logic signed [W-1:0] z0,
`ifdef CORDIC_VALID_EN
    input  logic                in_valid,
    output logic                out_valid,
`endif
    output logic signed [W-1:0] X,
    output logic signed [W-1:0] Y
);

    // atan(2^-i) in Q16.16, rounded
    function automatic logic signed [W-1:0] atan_rom(input int unsigned idx);
        case (idx)
            0:       atan_rom = W'(51472);
            1:       atan_rom = W'(30386);
            2:       atan_rom = W'(16055);
            3:       atan_rom = W'(8150);
            4:       atan_rom = W'(4091);
            5:       atan_rom = W'(2047);
            6:       atan_rom = W'(1024);
            7:       atan_rom = W'(512);
            8:       atan_rom = W'(256);
            9:       atan_rom = W'(128);
            10:      atan_rom = W'(64);
            11:      atan_rom = W'(32);
            12:      atan_rom = W'(16);
            13:      atan_rom = W'(8);
            14:      atan_rom = W'(4);
            15:      atan_rom = W'(2);
            default: atan_rom = '0;
        endcase
    endfunction

    logic signed [W-1:0] r_x [ITER];
    logic signed [W-1:0] r_y [ITER];
    logic signed [W-1:0] r_z [ITER];

    logic signed [W-1:0] w_xin [ITER];
    logic signed [W-1:0] w_yin [ITER];
    logic signed [W-1:0] w_zin [ITER];
    logic signed [W-1:0] w_xnx [ITER];
    logic signed [W-1:0] w_ynx [ITER];
    logic signed [W-1:0] w_znx [ITER];

    // Per-stage micro-rotation; direction follows the sign of the residual angle
    always_comb begin : stage_comb
        w_xin = '{default: '0};
        w_yin = '{default: '0};
        w_zin = '{default: '0};
        w_xnx = '{default: '0};
        w_ynx = '{default: '0};
        w_znx = '{default: '0};

        w_xin[0] = x0;
        w_yin[0] = y0;
        w_zin[0] = z0;
        for (int unsigned i = 1; i < ITER; i++) begin
            w_xin[i] = r_x[i-1];
            w_yin[i] = r_y[i-1];
            w_zin[i] = r_z[i-1];
        end

        for (int unsigned i = 0; i < ITER; i++) begin
            if (!w_zin[i][W-1]) begin
                w_xnx[i] = w_xin[i] - (w_yin[i] >>> i);
                w_ynx[i] = w_yin[i] + (w_xin[i] >>> i);
                w_znx[i] = w_zin[i] - atan_rom(i);
            end else begin
                w_xnx[i] = w_xin[i] + (w_yin[i] >>> i);
                w_ynx[i] = w_yin[i] - (w_xin[i] >>> i);
                w_znx[i] = w_zin[i] + atan_rom(i);
            end
        end
    end

    // Pipeline registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin : stage_regs
        if (!rst_n) begin
            for (int unsigned i = 0; i < ITER; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_z[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < ITER; i++) begin
                r_x[i] <= w_xnx[i];
                r_y[i] <= w_ynx[i];
                r_z[i] <= w_znx[i];
            end
        end
    end

    assign X = r_x[ITER-1];
    assign Y = r_y[ITER-1];

`ifdef CORDIC_VALID_EN
    logic [ITER-1:0] r_vld;

    // Valid bit travels alongside the data
    always_ff @(posedge clk or negedge rst_n) begin : valid_regs
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= in_valid;
            for (int unsigned i = 1; i < ITER; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    assign out_valid = r_vld[ITER-1];
`endif

endmodule

// File: tb/tb_cordic_updated.sv
// ----------------------------------------------------------------------------
// tb_cordic_updated
// Scoreboard bench for cordic_updated. Stimulus pushes the expected result of
// every sampled input (untimed reference rotation plus, for directed vectors,
// the ideal K-scaled trigonometric result) into a queue tagged with the cycle
// it is due; an independent monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_cordic_updated;

    localparam int unsigned W    = 32;
    localparam int unsigned ITER = 16;
    localparam real         KGAIN = 1.6467602581210656;
    localparam real         TOL   = 8.0;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [W-1:0] x0, y0, z0;
    logic signed [W-1:0] X, Y;
`ifdef CORDIC_VALID_EN
    logic               in_valid;
    logic               out_valid;
`endif

    cordic_updated #(.W(W), .ITER(ITER)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x0       (x0),
        .y0       (y0),
        .z0       (z0),
`ifdef CORDIC_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .X        (X),
        .Y        (Y)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int  due;
        int  ex;
        int  ey;
        bit  ev;
        bit  ideal;
        real ix;
        real iy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Untimed reference: ITER micro-rotations on 32-bit wrapping integers
    function automatic void ref_rotate(input int x, input int y, input int z,
                                       output int xo, output int yo);
        int atan_t [16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                            256, 128, 64, 32, 16, 8, 4, 2};
        int xn, yn;
        for (int k = 0; k < int'(ITER); k++) begin
            if (z >= 0) begin
                xn = x - (y >>> k);
                yn = y + (x >>> k);
                z  = z - atan_t[k];
            end else begin
                xn = x + (y >>> k);
                yn = y - (x >>> k);
                z  = z + atan_t[k];
            end
            x = xn;
            y = yn;
        end
        xo = x;
        yo = y;
    endfunction

    function automatic exp_t make_exp(input int x, input int y, input int z,
                                      input bit v, input bit ideal, input int due);
        exp_t e;
        real  zr;
        ref_rotate(x, y, z, e.ex, e.ey);
        zr      = real'(z) / 65536.0;
        e.ix    = KGAIN * (real'(x) * $cos(zr) - real'(y) * $sin(zr));
        e.iy    = KGAIN * (real'(x) * $sin(zr) + real'(y) * $cos(zr));
        e.due   = due;
        e.ev    = v;
        e.ideal = ideal;
        return e;
    endfunction

    function automatic exp_t zero_exp(input int due);
        exp_t e;
        e.due = due; e.ex = 0; e.ey = 0; e.ev = 1'b0;
        e.ideal = 1'b0; e.ix = 0.0; e.iy = 0.0;
        return e;
    endfunction

    task automatic chk_eq(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input real ideal);
        real d;
        checks++;
        d = real'(act) - ideal;
        if (d > TOL || d < -TOL) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0d expected %0f +-8", nm, cyc, act, ideal);
        end
    endtask

    // Monitor: zero checks while in reset, scoreboard pops otherwise
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                chk_eq("reset_X", X, 0);
                chk_eq("reset_Y", Y, 0);
`ifdef CORDIC_VALID_EN
                chk_eq("reset_valid", int'(out_valid), 0);
`endif
            end else begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    e = q.pop_front();
                    chk_eq("missed_slot", cyc, e.due);
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    chk_eq("X", X, e.ex);
                    chk_eq("Y", Y, e.ey);
`ifdef CORDIC_VALID_EN
                    chk_eq("out_valid", int'(out_valid), int'(e.ev));
`endif
                    if (e.ideal) begin
                        chk_tol("X_ideal", X, e.ix);
                        chk_tol("Y_ideal", Y, e.iy);
                    end
                end
            end
        end
    end

    task automatic apply(input int x, input int y, input int z, input bit v, input bit ideal);
        @(negedge clk);
        x0 = x; y0 = y; z0 = z;
`ifdef CORDIC_VALID_EN
        in_valid = v;
`endif
        q.push_back(make_exp(x, y, z, v, ideal, cyc + int'(ITER)));
    endtask

    // Async reset between edges, hold with nonzero inputs, release on a negedge
    task automatic reset_cycle(input int hold);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        x0 = 32'sd40000; y0 = -32'sd12345; z0 = 32'sd30000;
`ifdef CORDIC_VALID_EN
        in_valid = 1'b1;
`endif
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k < int'(ITER); k++) q.push_back(zero_exp(cyc + k));
        q.push_back(make_exp(40000, -12345, 30000, 1'b1, 1'b0, cyc + int'(ITER)));
    endtask

    function automatic int rnd_small();
        return int'($urandom_range(0, 65536)) - 32768;
    endfunction

    function automatic int rnd_angle();
        return int'($urandom_range(0, 205886)) - 102943;
    endfunction

    initial begin : stimulus
        rst_n = 1'b1;
        x0 = '0; y0 = '0; z0 = '0;
`ifdef CORDIC_VALID_EN
        in_valid = 1'b0;
`endif
        reset_cycle(5);

        // 90 degrees held: settles and stays stable
        repeat (ITER + 4) apply(65536, 0, 102943, 1'b1, 1'b1);
        apply(65536, 0, 0, 1'b1, 1'b1);
        apply(65536, 0, -102943, 1'b1, 1'b1);

        // Streaming burst framed by invalid samples
        repeat (3) apply(rnd_small(), rnd_small(), rnd_angle(), 1'b0, 1'b0);
        apply(65536, 0, 0,      1'b1, 1'b1);
        apply(65536, 0, 51472,  1'b1, 1'b1);
        apply(65536, 0, 102943, 1'b1, 1'b1);
        repeat (3) apply(rnd_small(), rnd_small(), rnd_angle(), 1'b0, 1'b0);

        // Random stream, occasionally full-range (wrapping, out-of-domain)
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0)
                apply(int'($urandom), int'($urandom), int'($urandom),
                      1'($urandom_range(0, 1)), 1'b0);
            else
                apply(rnd_small(), rnd_small(), rnd_angle(),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset while results are in flight and on the outputs
        repeat (ITER + 3) apply(65536, 0, 102943, 1'b1, 1'b0);
        reset_cycle(3);
        repeat (ITER + 2) apply(rnd_small(), rnd_small(), rnd_angle(), 1'b1, 1'b0);
        apply(-65536, 0, 51472, 1'b1, 1'b1);

        // Drain, then confirm every expectation was consumed
        repeat (ITER + 2) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
